// File: rtl/spi_burst_feeder_pkg.sv
// Shared types for the SPI burst feeder: burst sequencer state and byte width.
package spi_burst_feeder_pkg;

  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    IDLE_B = 2'd0,
    RUN    = 2'd1,
    DRAIN  = 2'd2,
    FIN    = 2'd3
  } burst_state_t;

endpackage

// File: rtl/spi_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers for exact full/empty.
module spi_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic             i_master_clk,
  input  logic             i_master_rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_wr;
  logic             do_rd;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_rd   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write to a full FIFO still lands.
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_master_clk or negedge i_master_rst_n) begin
    if (!i_master_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (do_wr) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_rd) rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

endmodule

// File: rtl/spi_burst_feeder.sv
// Streams a host-preloaded TX FIFO into the SPI master back-to-back and gathers the
// returned bytes into an RX FIFO, pulsing DONE once LEN bytes have come back.
module spi_burst_feeder
  import spi_burst_feeder_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int LEN_W      = 8
) (
  input  logic              i_master_clk,
  input  logic              i_master_rst_n,
  input  logic              i_HOST_WR_EN,
  input  logic [BYTE_W-1:0] i_HOST_WR_DATA,
  input  logic              i_HOST_START,
  input  logic [LEN_W-1:0]  i_HOST_LEN,
  input  logic              i_HOST_RD_EN,
  output logic [BYTE_W-1:0] o_HOST_RD_DATA,
  output logic              o_HOST_RX_EMPTY,
  output logic              o_HOST_TX_FULL,
  output logic              o_HOST_BUSY,
  output logic              o_HOST_DONE,
  output logic              o_HOST_RX_OVF,
  output logic              o_HOST_TX_UNDR,
  input  logic              i_HOST_CLR_ERR,
  output logic              o_TX_VALID,
  output logic [BYTE_W-1:0] o_TX_BYTE,
  input  logic              i_TX_READY,
  input  logic              i_RX_VALID,
  input  logic [BYTE_W-1:0] i_RX_BYTE,
  output burst_state_t      o_dbg_state
);

  localparam logic [LEN_W-1:0] CNT_ONE = LEN_W'(1);

  burst_state_t     state_q;
  burst_state_t     state_d;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] tx_sent_q;
  logic [LEN_W-1:0] tx_sent_nxt;
  logic [LEN_W-1:0] rx_got_q;
  logic             ovf_q;
  logic             undr_q;
  logic             busy;
  logic             tx_empty;
  logic             tx_fire;
  logic             rx_full;
  logic             rx_empty;
  logic             rx_push;
  logic             start_ok;
  logic             ovf_set;
  logic             undr_set;

  // Handshake: a byte moves to the master on any edge where o_TX_VALID and i_TX_READY
  // are both high; the FIFO pops and tx_sent advances on that same edge. i_TX_READY
  // without o_TX_VALID does nothing. i_RX_VALID is a one-cycle pulse per byte.
  assign busy        = (state_q == RUN) || (state_q == DRAIN);
  assign o_TX_VALID  = (state_q == RUN) && (tx_sent_q < len_q) && !tx_empty;
  assign tx_fire     = o_TX_VALID && i_TX_READY;
  assign tx_sent_nxt = tx_sent_q + (tx_fire ? CNT_ONE : '0);
  assign rx_push     = i_RX_VALID && busy;
  assign start_ok    = (state_q == IDLE_B) && i_HOST_START;
  // A pop can only happen on a non-empty FIFO, and a full one never is.
  assign ovf_set     = rx_push && rx_full && !i_HOST_RD_EN;
  assign undr_set    = (state_q == RUN) && (tx_sent_q < len_q) && tx_empty;

  spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .i_master_clk   (i_master_clk),
    .i_master_rst_n (i_master_rst_n),
    .wr_en          (i_HOST_WR_EN),
    .wr_data        (i_HOST_WR_DATA),
    .rd_en          (tx_fire),
    .rd_data        (o_TX_BYTE),
    .full           (o_HOST_TX_FULL),
    .empty          (tx_empty)
  );

  spi_sync_fifo #(.WIDTH(BYTE_W), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .i_master_clk   (i_master_clk),
    .i_master_rst_n (i_master_rst_n),
    .wr_en          (rx_push),
    .wr_data        (i_RX_BYTE),
    .rd_en          (i_HOST_RD_EN),
    .rd_data        (o_HOST_RD_DATA),
    .full           (rx_full),
    .empty          (rx_empty)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE_B: if (i_HOST_START) state_d = (i_HOST_LEN == '0) ? FIN : RUN;
      RUN:    if (tx_sent_nxt == len_q) state_d = DRAIN;
      DRAIN:  if (rx_got_q == len_q) state_d = FIN;
      FIN:    state_d = IDLE_B;
      default: state_d = IDLE_B;
    endcase
  end

  always_ff @(posedge i_master_clk or negedge i_master_rst_n) begin
    if (!i_master_rst_n) begin
      state_q   <= IDLE_B;
      len_q     <= '0;
      tx_sent_q <= '0;
      rx_got_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start_ok) begin
        len_q     <= i_HOST_LEN;
        tx_sent_q <= '0;
        rx_got_q  <= '0;
      end else begin
        tx_sent_q <= tx_sent_nxt;
        if (rx_push) rx_got_q <= rx_got_q + CNT_ONE;
      end
    end
  end

  // Sticky error flags; a clear request wins over a same-cycle set.
  always_ff @(posedge i_master_clk or negedge i_master_rst_n) begin
    if (!i_master_rst_n) begin
      ovf_q  <= 1'b0;
      undr_q <= 1'b0;
    end else if (i_HOST_CLR_ERR) begin
      ovf_q  <= 1'b0;
      undr_q <= 1'b0;
    end else begin
      if (ovf_set)  ovf_q  <= 1'b1;
      if (undr_set) undr_q <= 1'b1;
    end
  end

  assign o_HOST_BUSY     = busy;
  assign o_HOST_DONE     = (state_q == FIN);
  assign o_HOST_RX_EMPTY = rx_empty;
  assign o_HOST_RX_OVF   = ovf_q;
  assign o_HOST_TX_UNDR  = undr_q;
  assign o_dbg_state     = state_q;

endmodule
